// File: rtl/uart_tx_engine.sv
// UART transmit serializer: pops words from the TX FIFO (asynchronous read) and
// frames them on Tx as start, LSB-first data, optional parity and stop bits.
module uart_tx_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int SB_TICK    = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  S_tick,
  input  logic                  Fifo_empty,
  input  logic [DATA_WIDTH-1:0] Fifo_rdata,
  output logic                  Fifo_rd,
  output logic                  Tx,
  output logic                  Tx_busy,
  output logic                  Tx_done_tick
);

  localparam int            NW        = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [NW-1:0] N_LAST    = NW'(DATA_WIDTH - 1);
  localparam logic [5:0]    BIT_LAST  = 6'd15;
  localparam logic [5:0]    STOP_LAST = 6'(SB_TICK - 1);
  localparam logic          PAR_INIT  = (PARITY_ODD != 0) ? 1'b1 : 1'b0;
  localparam logic          PAR_ON    = (PARITY_EN != 0) ? 1'b1 : 1'b0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state_r;
  logic [5:0]            s_cnt_r;
  logic [NW-1:0]         n_cnt_r;
  logic [DATA_WIDTH-1:0] b_reg_r;
  logic                  parity_r;
  logic                  tx_level_s;

  function automatic logic parity_fold(input logic acc, input logic data_bit);
    return acc ^ data_bit;
  endfunction

  // Line level for the current state; Tx registers it, so the line lags the state by one Clk.
  always_comb begin
    tx_level_s = 1'b1;
    case (state_r)
      IDLE:    tx_level_s = 1'b1;
      START:   tx_level_s = 1'b0;
      DATA:    tx_level_s = b_reg_r[0];
      PARITY:  tx_level_s = parity_r;
      STOP:    tx_level_s = 1'b1;
      default: tx_level_s = 1'b1;
    endcase
  end

  // Frame sequencer: state, tick/bit counters, shift register and registered outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r      <= IDLE;
      s_cnt_r      <= 6'd0;
      n_cnt_r      <= {NW{1'b0}};
      b_reg_r      <= {DATA_WIDTH{1'b0}};
      parity_r     <= 1'b0;
      Tx           <= 1'b1;
      Fifo_rd      <= 1'b0;
      Tx_busy      <= 1'b0;
      Tx_done_tick <= 1'b0;
    end else begin
      Tx           <= tx_level_s;
      Fifo_rd      <= 1'b0;
      Tx_done_tick <= 1'b0;
      case (state_r)
        IDLE: begin
          if (!Fifo_empty) begin
            b_reg_r  <= Fifo_rdata;
            Fifo_rd  <= 1'b1;
            s_cnt_r  <= 6'd0;
            parity_r <= PAR_INIT;
            Tx_busy  <= 1'b1;
            state_r  <= START;
          end else begin
            state_r  <= IDLE;
          end
        end
        START: begin
          if (S_tick) begin
            if (s_cnt_r == BIT_LAST) begin
              s_cnt_r <= 6'd0;
              n_cnt_r <= {NW{1'b0}};
              state_r <= DATA;
            end else begin
              s_cnt_r <= s_cnt_r + 6'd1;
            end
          end
        end
        DATA: begin
          if (S_tick) begin
            if (s_cnt_r == BIT_LAST) begin
              s_cnt_r  <= 6'd0;
              parity_r <= parity_fold(parity_r, b_reg_r[0]);
              b_reg_r  <= b_reg_r >> 1;
              if (n_cnt_r == N_LAST) begin
                n_cnt_r <= {NW{1'b0}};
                if (PAR_ON) begin
                  state_r <= PARITY;
                end else begin
                  state_r <= STOP;
                end
              end else begin
                n_cnt_r <= n_cnt_r + NW'(1);
              end
            end else begin
              s_cnt_r <= s_cnt_r + 6'd1;
            end
          end
        end
        PARITY: begin
          if (S_tick) begin
            if (s_cnt_r == BIT_LAST) begin
              s_cnt_r <= 6'd0;
              state_r <= STOP;
            end else begin
              s_cnt_r <= s_cnt_r + 6'd1;
            end
          end
        end
        STOP: begin
          if (S_tick) begin
            if (s_cnt_r == STOP_LAST) begin
              s_cnt_r      <= 6'd0;
              Tx_done_tick <= 1'b1;
              Tx_busy      <= 1'b0;
              state_r      <= IDLE;
            end else begin
              s_cnt_r <= s_cnt_r + 6'd1;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          Tx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: three lanes (no parity/1 stop, even/1.5 stop, odd/2 stop),
// each fed by a FIFO model and decoded by a reference receiver against a scoreboard.
module tb_uart_tx_engine;

  localparam int NI      = 3;
  localparam int BIT_CLK = 64;

  typedef struct packed { logic [7:0] d; logic p; } exp_t;
  typedef struct packed { logic [1:0] inst; logic [7:0] d; logic p; } vec_t;

  logic       clk = 1'b0;
  logic       s_tick;
  logic       rst_s   [NI];
  logic       empty_s [NI];
  logic [7:0] rdata_s [NI];
  logic       rd_s    [NI];
  logic       tx_s    [NI];
  logic       busy_s  [NI];
  logic       done_s  [NI];

  logic [7:0] fifo_q [NI][$];
  exp_t       sb_q   [NI][$];
  int pushed_n  [NI];
  int pops_n    [NI];
  int done_n    [NI];
  int aborted_n [NI];
  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
    end
  endtask

  task automatic push(input int g, input logic [7:0] d, input logic p);
    fifo_q[g].push_back(d);
    sb_q[g].push_back('{d: d, p: p});
    pushed_n[g]++;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    bit pending;
    do begin
      @(posedge clk); #1;
      n++;
      pending = 1'b0;
      for (int g = 0; g < NI; g++)
        if (busy_s[g] !== 1'b0 || sb_q[g].size() != 0 || fifo_q[g].size() != 0) pending = 1'b1;
    end while (pending && n < budget);
    check("drain_timeout", {31'd0, pending}, 32'd0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Baud tick every 4 Clk and FIFO models (pop on Fifo_rd), all driven on the falling edge.
  initial begin : drv
    int tcnt;
    tcnt = 0;
    s_tick = 1'b0;
    for (int g = 0; g < NI; g++) begin
      empty_s[g] = 1'b1;
      rdata_s[g] = 8'h00;
    end
    forever begin
      @(negedge clk);
      s_tick = (tcnt == 3);
      tcnt = (tcnt + 1) % 4;
      for (int g = 0; g < NI; g++) begin
        if (rd_s[g] === 1'b1) begin
          pops_n[g]++;
          check($sformatf("rd_nonempty%0d", g), {31'd0, fifo_q[g].size() != 0}, 32'd1);
          if (fifo_q[g].size() != 0) void'(fifo_q[g].pop_front());
        end
        empty_s[g] = (fifo_q[g].size() == 0);
        rdata_s[g] = (fifo_q[g].size() != 0) ? fifo_q[g][0] : 8'h00;
      end
    end
  end

  for (genvar g = 0; g < NI; g++) begin : g_lane
    localparam int SBT    = (g == 0) ? 16 : ((g == 1) ? 24 : 32);
    localparam int PEN    = (g == 0) ? 0 : 1;
    localparam int PODD   = (g == 2) ? 1 : 0;
    localparam int LEN_LO = 60 + BIT_CLK * (8 + PEN) + 4 * SBT;

    uart_tx_engine #(
      .DATA_WIDTH(8),
      .SB_TICK(SBT),
      .PARITY_EN(PEN),
      .PARITY_ODD(PODD)
    ) u_dut (
      .Clk(clk),
      .Reset(rst_s[g]),
      .S_tick(s_tick),
      .Fifo_empty(empty_s[g]),
      .Fifo_rdata(rdata_s[g]),
      .Fifo_rd(rd_s[g]),
      .Tx(tx_s[g]),
      .Tx_busy(busy_s[g]),
      .Tx_done_tick(done_s[g])
    );

    // Reference receiver: mid-bit sampling off the start edge, bit-grid and frame timing checks.
    initial begin : rx
      int t0, t1, k, idx, last_rise, last_done;
      bit act, open, gap_pend, last_bit;
      logic prev_tx, par;
      logic [7:0] data;
      exp_t e;
      act = 1'b0; open = 1'b0; gap_pend = 1'b0; last_bit = 1'b1;
      prev_tx = 1'b1; par = 1'b0; data = 8'h00;
      t0 = 0; t1 = -1; last_rise = 0; last_done = 0;
      forever begin
        @(posedge clk); #1;
        if (rst_s[g] !== 1'b0) begin
          act = 1'b0; open = 1'b0; gap_pend = 1'b0;
          prev_tx = 1'b1;
        end else begin
          if (done_s[g] === 1'b1) begin
            done_n[g]++;
            check($sformatf("done_in_frame%0d", g), {31'd0, open}, 32'd1);
            if (open) begin
              check_range($sformatf("frame_len%0d", g), cyc - t0, LEN_LO, LEN_LO + 3);
              if (!last_bit) check($sformatf("stop_len%0d", g), cyc - last_rise, 4 * SBT - 1);
              open = 1'b0;
              last_done = cyc;
              gap_pend = (fifo_q[g].size() != 0);
            end
          end
          if (!act && prev_tx === 1'b1 && tx_s[g] === 1'b0) begin
            if (gap_pend) check_range($sformatf("b2b_gap%0d", g), cyc - last_done, 1, 2);
            gap_pend = 1'b0;
            act = 1'b1; open = 1'b1;
            t0 = cyc; t1 = -1; data = 8'h00; par = 1'b0;
          end else if (act) begin
            k = cyc - t0;
            if (tx_s[g] !== prev_tx) begin
              if (t1 < 0) begin
                check($sformatf("start_len%0d", g), {31'd0, ((k + 3) % BIT_CLK) < 4}, 32'd1);
                t1 = cyc;
              end else begin
                check($sformatf("bit_grid%0d", g), (cyc - t1) % BIT_CLK, 32'd0);
              end
              if (tx_s[g] === 1'b1) last_rise = cyc;
            end
            if (k == 30) begin
              check($sformatf("start_level%0d", g), {31'd0, tx_s[g]}, 32'd0);
              check($sformatf("busy_in_frame%0d", g), {31'd0, busy_s[g]}, 32'd1);
            end else if (k >= 94 && ((k - 30) % BIT_CLK) == 0) begin
              idx = (k - 30) / BIT_CLK - 1;
              if (idx < 8) begin
                data[idx] = tx_s[g];
              end else if (PEN != 0 && idx == 8) begin
                par = tx_s[g];
              end else begin
                check($sformatf("stop_level%0d", g), {31'd0, tx_s[g]}, 32'd1);
                act = 1'b0;
                last_bit = (PEN != 0) ? par : data[7];
                check($sformatf("frame_expected%0d", g), {31'd0, sb_q[g].size() != 0}, 32'd1);
                if (sb_q[g].size() != 0) begin
                  e = sb_q[g].pop_front();
                  check($sformatf("data%0d", g), {24'd0, data}, {24'd0, e.d});
                  if (PEN != 0) check($sformatf("parity%0d", g), {31'd0, par}, {31'd0, e.p});
                end
              end
            end
          end
          prev_tx = tx_s[g];
        end
      end
    end
  end

  initial begin : main
    vec_t vecs [11];
    int   bad  [NI];
    int   n;
    vecs[0]  = '{2'd0, 8'hA5, 1'b0};
    vecs[1]  = '{2'd0, 8'h3C, 1'b0};
    vecs[2]  = '{2'd0, 8'hFF, 1'b0};
    vecs[3]  = '{2'd1, 8'h07, 1'b1};
    vecs[4]  = '{2'd1, 8'h00, 1'b0};
    vecs[5]  = '{2'd1, 8'h80, 1'b1};
    vecs[6]  = '{2'd1, 8'hFE, 1'b1};
    vecs[7]  = '{2'd2, 8'h07, 1'b0};
    vecs[8]  = '{2'd2, 8'h01, 1'b0};
    vecs[9]  = '{2'd2, 8'h03, 1'b1};
    vecs[10] = '{2'd2, 8'hFF, 1'b1};

    for (int g = 0; g < NI; g++) begin
      rst_s[g] = 1'b1;
      pushed_n[g] = 0; pops_n[g] = 0; done_n[g] = 0; aborted_n[g] = 0;
    end
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
    for (int g = 0; g < NI; g++) begin
      check($sformatf("reset_tx%0d", g),   {31'd0, tx_s[g]},   32'd1);
      check($sformatf("reset_rd%0d", g),   {31'd0, rd_s[g]},   32'd0);
      check($sformatf("reset_busy%0d", g), {31'd0, busy_s[g]}, 32'd0);
      check($sformatf("reset_done%0d", g), {31'd0, done_s[g]}, 32'd0);
    end
    @(negedge clk);
    for (int g = 0; g < NI; g++) rst_s[g] = 1'b0;

    // Ticks running with an empty FIFO: the line must stay idle.
    for (int g = 0; g < NI; g++) bad[g] = 0;
    repeat (2000) begin
      @(posedge clk); #1;
      for (int g = 0; g < NI; g++)
        if (tx_s[g] !== 1'b1 || rd_s[g] !== 1'b0 || busy_s[g] !== 1'b0) bad[g]++;
    end
    for (int g = 0; g < NI; g++) check($sformatf("empty_idle%0d", g), bad[g], 32'd0);

    // Single frame, 0x55.
    @(negedge clk);
    push(0, 8'h55, 1'b0);
    wait_drain(3000);
    check("basic_pops", pops_n[0], 32'd1);
    check("basic_done", done_n[0], 32'd1);

    // Vector table: all bytes queued at once, so each lane also runs back-to-back.
    @(negedge clk);
    for (int i = 0; i < 11; i++) push(int'(vecs[i].inst), vecs[i].d, vecs[i].p);
    wait_drain(8000);

    // Reset during data bit 3 of 0xC3: that byte is lost, the next one must be intact.
    @(negedge clk);
    fifo_q[0].push_back(8'hC3);
    pushed_n[0]++;
    aborted_n[0]++;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (tx_s[0] !== 1'b0 && n < 200);
    check("c3_start", {31'd0, tx_s[0]}, 32'd0);
    repeat (280) @(posedge clk);
    #1;
    check("c3_busy_mid", {31'd0, busy_s[0]}, 32'd1);
    @(negedge clk);
    rst_s[0] = 1'b1;
    @(posedge clk); #1;
    check("mid_reset_tx",   {31'd0, tx_s[0]},   32'd1);
    check("mid_reset_busy", {31'd0, busy_s[0]}, 32'd0);
    check("mid_reset_done", {31'd0, done_s[0]}, 32'd0);
    @(negedge clk);
    rst_s[0] = 1'b0;
    repeat (200) @(negedge clk);
    push(0, 8'h5A, 1'b0);
    wait_drain(3000);

    for (int g = 0; g < NI; g++) begin
      check($sformatf("pop_count%0d", g),  pops_n[g], pushed_n[g]);
      check($sformatf("done_count%0d", g), done_n[g], pushed_n[g] - aborted_n[g]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_engine.md
# uart_tx_engine

Transmit-side serializer of the UART: the read end of the TX FIFO register file. It pops bytes from the FIFO through the asynchronous-read interface and shifts each one out on `Tx` as an asynchronous serial frame: start bit, LSB-first data, optional parity, stop bit(s). Bit timing comes from the shared 16x oversampling baud-tick generator.

## Interface
- `DATA_WIDTH`, 8: data bits per frame (5–9).
- `SB_TICK`, 16: stop-bit duration in `S_tick`s (16 = 1 stop, 24 = 1.5, 32 = 2; max 63).
- `PARITY_EN`, 0: 1 inserts a parity bit after the data.
- `PARITY_ODD`, 0: 1 selects odd parity, 0 selects even; ignored when `PARITY_EN`=0.

- `Clk`, in, 1: single clock; all logic on the rising edge.
- `Reset`, in, 1: synchronous, active-high reset.
- `S_tick`, in, 1: one-`Clk` pulse at 16x the baud rate.
- `Fifo_empty`, in, 1: TX FIFO holds no data.
- `Fifo_rdata`, in, DATA_WIDTH: FIFO head word; valid in the same cycle (asynchronous read).
- `Fifo_rd`, out, 1: one-cycle pop strobe; advances the FIFO read pointer.
- `Tx`, out, 1: serial line; idles high.
- `Tx_busy`, out, 1: high whenever state ≠ IDLE.
- `Tx_done_tick`, out, 1: one-cycle pulse when a frame's stop bit completes.

## Operation
- **States:** IDLE, START, DATA, PARITY, STOP. Registers:
  - tick counter `s_cnt`: 6 bits.
  - bit counter `n_cnt`: ⌈log2 DATA_WIDTH⌉ bits.
  - shift register `b_reg`: DATA_WIDTH bits.
  - parity accumulator.
  - registered `Tx`.
- **IDLE:** `Tx`=1 and `S_tick` is ignored. When `Fifo_empty`=0, on that edge:
  - load `Fifo_rdata` into `b_reg`;
  - assert `Fifo_rd` for exactly that cycle;
  - clear `s_cnt`;
  - load the parity accumulator with `PARITY_ODD`;
  - go to START.
- **START:** `Tx`=0. On each `S_tick` increment `s_cnt`. On the `S_tick` with `s_cnt`=15: clear `s_cnt` and `n_cnt`, go to DATA.
- **DATA:** `Tx`=`b_reg[0]`. On the `S_tick` with `s_cnt`=15:
  - XOR `b_reg[0]` into parity, shift `b_reg` right, clear `s_cnt`;
  - if `n_cnt`=DATA_WIDTH−1, go to PARITY (`PARITY_EN`=1) or STOP; otherwise increment `n_cnt`.
- **PARITY:** `Tx`=accumulated parity (even: XOR of the data bits; odd: its inverse). After 16 ticks go to STOP.
- **STOP:** `Tx`=1. On the `S_tick` with `s_cnt`=SB_TICK−1: pulse `Tx_done_tick` and go to IDLE.
- **Pop rules:** `Fifo_rd` asserts only in IDLE with `Fifo_empty`=0, never more than once per frame, and never while `Fifo_empty`=1.
- **Reset mid-frame:** on the next edge the block goes to IDLE, `Tx`=1, all counters clear, and no done pulse is issued. The byte already popped is discarded.
- **`S_tick` with no FIFO data:** the block stays in IDLE and `Fifo_rd` never asserts.

## Timing
- **Reset values:** `Tx`=1, `Fifo_rd`=0, `Tx_busy`=0, `Tx_done_tick`=0, state IDLE, all counters 0.
- **Start latency:** `Tx` falls on the clock edge after the cycle in which `Fifo_rd` is high. `Tx` is registered, so every line transition lags its state decision by one `Clk`.
- **Start bit length:** from the load edge through the 16th `S_tick` seen in START; this is 16 ticks plus the phase offset to the first tick.
- **Bit widths:** each data and parity bit spans exactly 16 `S_tick` periods; the stop bit spans SB_TICK periods.
- **Frame length:** (1 + DATA_WIDTH + PARITY_EN)·16 + SB_TICK ticks.
- **`Tx_done_tick`:** high for the single cycle in which the state is STOP→IDLE.
- **Back-to-back frames:** if the FIFO is non-empty, the next `Fifo_rd` occurs in the first IDLE cycle, one `Clk` after `Tx_done_tick`. The minimum idle-high gap between frames is 1 `Clk`.
- **Coincident events:** `Fifo_empty` dropping in the same cycle as the STOP→IDLE transition does not start a frame until the following cycle.

## Test plan
- **Basic frame:** DATA_WIDTH=8, no parity, SB_TICK=16, `S_tick` every 4 `Clk`; push 0x55 → exactly one `Fifo_rd`; `Tx` shows 0,1,0,1,0,1,0,1,0,1 (start + LSB-first), each bit 64 `Clk`; stop high for 64 `Clk`; one `Tx_done_tick`.
- **Even parity:** PARITY_EN=1, PARITY_ODD=0; send 0x07 → parity bit 1. With PARITY_ODD=1 → 0. Send 0x00 even → 0.
- **Back-to-back:** preload 0xA5, 0x3C, 0xFF → three `Fifo_rd` pulses; each new start bit begins 1–2 `Clk` after the previous `Tx_done_tick`; bytes decoded by the reference receiver model match in order.
- **Empty FIFO:** `Fifo_empty`=1 for 2000 `Clk` with ticks running → `Tx`=1, `Fifo_rd`=0, `Tx_busy`=0 throughout.
- **Stop-bit variants:** SB_TICK=24 and SB_TICK=32 → stop-high duration of 24 and 32 tick periods before `Tx_done_tick`.
- **Reset mid-frame:** assert `Reset` for 1 `Clk` during the DATA bit-3 of 0xC3 → next edge `Tx`=1, `Tx_busy`=0, no `Tx_done_tick`; the next FIFO byte is then transmitted intact.
